// File: rtl/cpu_io_stage.sv
// Serial I/O stage: 8N1 UART transmitter and receiver feeding the CPU I/O special registers.
// Build option CPU_IO_RX_FIFO_EN replaces the single receive register with a 4-entry receive FIFO.
module cpu_io_stage #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic       ex_w_req,
  input  logic [7:0] ex_w_data,
  input  logic       ex_ack,
  output logic       sr_irr,
  output logic       sr_w_busy,
  output logic [7:0] sr_r_data
);

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] DIV_HALF = 16'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                            RX_FERR = 3'd4} rx_state_t;

  tx_state_t   tx_state_r, tx_state_s;
  logic [15:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]  tx_bit_r, tx_bit_s;
  logic [7:0]  tx_shift_r, tx_shift_s;
  logic        tx_line_r, tx_line_s;
  logic        tx_busy_r, tx_busy_s;

  rx_state_t   rx_state_r, rx_state_s;
  logic [15:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]  rx_bit_r, rx_bit_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  logic        rx_commit_s;

  logic        irr_r;
  logic [7:0]  r_data_r;

  assign uart_tx   = tx_line_r;
  assign sr_w_busy = tx_busy_r;
  assign sr_irr    = irr_r;
  assign sr_r_data = r_data_r;

  // TX state and registered line/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      tx_line_r  <= tx_line_s;
      tx_busy_r  <= tx_busy_s;
    end
  end

  // TX next state; line and busy are computed for the next cycle so they stay registered
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    tx_line_s  = tx_line_r;
    tx_busy_s  = tx_busy_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (ex_w_req) begin
          tx_state_s = TX_START;
          tx_shift_s = ex_w_data;
          tx_cnt_s   = 16'd0;
          tx_busy_s  = 1'b1;
          tx_line_s  = 1'b0;
        end else begin
          tx_busy_s  = 1'b0;
          tx_line_s  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == DIV_LAST) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = 16'd0;
          tx_bit_s   = 3'd0;
          tx_line_s  = tx_shift_r[0];
          tx_shift_s = {1'b0, tx_shift_r[7:1]};
        end else begin
          tx_cnt_s   = tx_cnt_r + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == DIV_LAST) begin
          tx_cnt_s = 16'd0;
          if (tx_bit_r == 3'd7) begin
            tx_state_s = TX_STOP;
            tx_line_s  = 1'b1;
          end else begin
            tx_bit_s   = tx_bit_r + 3'd1;
            tx_line_s  = tx_shift_r[0];
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == DIV_LAST) begin
          tx_state_s = TX_IDLE;
          tx_cnt_s   = 16'd0;
          tx_busy_s  = 1'b0;
          tx_line_s  = 1'b1;
        end else begin
          tx_cnt_s   = tx_cnt_r + 16'd1;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = 16'd0;
        tx_busy_s  = 1'b0;
        tx_line_s  = 1'b1;
      end
    endcase
  end

  // RX synchronizer and state registers; sync flops reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_meta_r  <= uart_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
    end
  end

  // RX next state; the edge-detect cycle counts as tick 0 of the start bit
  always_comb begin
    rx_state_s  = rx_state_r;
    rx_cnt_s    = rx_cnt_r;
    rx_bit_s    = rx_bit_r;
    rx_shift_s  = rx_shift_r;
    rx_commit_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = RX_START;
          rx_cnt_s   = 16'd1;
        end else begin
          rx_cnt_s   = 16'd0;
        end
      end
      RX_START: begin
        if (rx_cnt_r == DIV_HALF) begin
          rx_cnt_s = 16'd0;
          rx_bit_s = 3'd0;
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == DIV_LAST) begin
          rx_cnt_s   = 16'd0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_bit_s   = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == DIV_LAST) begin
          rx_cnt_s = 16'd0;
          if (rx_sync_r) begin
            rx_state_s  = RX_IDLE;
            rx_commit_s = 1'b1;
          end else begin
            rx_state_s  = RX_FERR;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + 16'd1;
        end
      end
      RX_FERR: begin
        if (rx_sync_r) begin
          rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_FERR;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = 16'd0;
      end
    endcase
  end

`ifdef CPU_IO_RX_FIFO_EN
  logic [7:0] fifo_mem_r [4];
  logic [1:0] fifo_rd_r, fifo_wr_r, fifo_rd_s, fifo_wr_s;
  logic [2:0] fifo_cnt_r, fifo_cnt_s;
  logic       fifo_push_s, fifo_pop_s;
  logic [7:0] fifo_head_s;

  // FIFO control; a full FIFO still accepts a byte when a pop frees a slot in the same cycle
  always_comb begin
    fifo_pop_s  = ex_ack && (fifo_cnt_r != 3'd0);
    fifo_push_s = rx_commit_s && ((fifo_cnt_r != 3'd4) || fifo_pop_s);
    fifo_rd_s   = fifo_pop_s ? (fifo_rd_r + 2'd1) : fifo_rd_r;
    fifo_wr_s   = fifo_push_s ? (fifo_wr_r + 2'd1) : fifo_wr_r;
    if (fifo_push_s && !fifo_pop_s) begin
      fifo_cnt_s = fifo_cnt_r + 3'd1;
    end else if (!fifo_push_s && fifo_pop_s) begin
      fifo_cnt_s = fifo_cnt_r - 3'd1;
    end else begin
      fifo_cnt_s = fifo_cnt_r;
    end
    if (fifo_cnt_s == 3'd0) begin
      fifo_head_s = 8'h00;
    end else if (fifo_push_s && (fifo_wr_r == fifo_rd_s)) begin
      fifo_head_s = rx_shift_r;
    end else begin
      fifo_head_s = fifo_mem_r[fifo_rd_s];
    end
  end

  // FIFO storage and registered head/non-empty outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      fifo_rd_r  <= 2'd0;
      fifo_wr_r  <= 2'd0;
      fifo_cnt_r <= 3'd0;
      irr_r      <= 1'b0;
      r_data_r   <= 8'h00;
    end else begin
      if (fifo_push_s) begin
        fifo_mem_r[fifo_wr_r] <= rx_shift_r;
      end
      fifo_rd_r  <= fifo_rd_s;
      fifo_wr_r  <= fifo_wr_s;
      fifo_cnt_r <= fifo_cnt_s;
      irr_r      <= (fifo_cnt_s != 3'd0);
      r_data_r   <= fifo_head_s;
    end
  end
`else
  // Single receive register; a commit overrides a simultaneous acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_r    <= 1'b0;
      r_data_r <= 8'h00;
    end else if (rx_commit_s) begin
      irr_r    <= 1'b1;
      r_data_r <= rx_shift_r;
    end else if (ex_ack) begin
      irr_r    <= 1'b0;
    end else begin
      irr_r    <= irr_r;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_io_stage.sv
// Bench for cpu_io_stage at BAUD_DIV=4: TX frames checked by a scoreboard monitor, RX by directed checks.
module tb_cpu_io_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       uart_tx;
  logic       ex_w_req;
  logic [7:0] ex_w_data;
  logic       ex_ack;
  logic       sr_irr;
  logic       sr_w_busy;
  logic [7:0] sr_r_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] cleared_data;

  cpu_io_stage #(.BAUD_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .ex_w_req(ex_w_req), .ex_w_data(ex_w_data), .ex_ack(ex_ack),
    .sr_irr(sr_irr), .sr_w_busy(sr_w_busy), .sr_r_data(sr_r_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX monitor: decodes each frame cycle by cycle and compares against the expected queue
  int         mon_cyc;
  int         mon_bad;
  int         mon_pos;
  logic       mon_active = 1'b0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc = 0;
        mon_bad = (sr_w_busy === 1'b1) ? 0 : 1;
        mon_byte = 8'h00;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc < 40) begin
        mon_pos = mon_cyc / 4;
        if (sr_w_busy !== 1'b1) mon_bad++;
        if (mon_pos == 0) begin
          if (uart_tx !== 1'b0) mon_bad++;
        end else if (mon_pos == 9) begin
          if (uart_tx !== 1'b1) mon_bad++;
        end else if (mon_cyc % 4 == 0) begin
          mon_byte[mon_pos-1] = uart_tx;
        end else if (uart_tx !== mon_byte[mon_pos-1]) begin
          mon_bad++;
        end
      end else begin
        if (sr_w_busy !== 1'b0 || uart_tx !== 1'b1) mon_bad++;
        check("tx_frame_shape_and_busy40", 32'(mon_bad), 32'd0);
        check("tx_frame_expected", 32'(exp_tx_q.size() > 0), 32'd1);
        if (exp_tx_q.size() > 0) begin
          mon_exp = exp_tx_q.pop_front();
          check("tx_frame_byte", 32'(mon_byte), 32'(mon_exp));
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic pulse_req(input logic [7:0] b);
    ex_w_data = b;
    ex_w_req = 1'b1;
    @(negedge clk);
    ex_w_req = 1'b0;
  endtask

  task automatic pulse_ack();
    ex_ack = 1'b1;
    @(negedge clk);
    ex_ack = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (sr_w_busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int busys;
`ifdef CPU_IO_RX_FIFO_EN
    cleared_data = 8'h00;
`else
    cleared_data = 8'h3C;
`endif
    rst_n = 1'b0; uart_rx = 1'b1; ex_w_req = 1'b0; ex_w_data = 8'h00; ex_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_busy", 32'(sr_w_busy), 32'd0);
    check("reset_irr", 32'(sr_irr), 32'd0);
    check("reset_rdata", 32'(sr_r_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5
    exp_tx_q.push_back(8'hA5);
    pulse_req(8'hA5);
    check("a5_start_busy", 32'(sr_w_busy), 32'd1);
    check("a5_start_tx", 32'(uart_tx), 32'd0);
    wait_tx_idle();
    repeat (3) @(negedge clk);

    // Request during busy is ignored; request in first idle cycle starts with no gap
    exp_tx_q.push_back(8'h22);
    pulse_req(8'h22);
    repeat (4) @(negedge clk);
    pulse_req(8'h11);
    wait_tx_idle();
    exp_tx_q.push_back(8'h33);
    pulse_req(8'h33);
    check("b2b_start_busy", 32'(sr_w_busy), 32'd1);
    check("b2b_start_tx", 32'(uart_tx), 32'd0);
    wait_tx_idle();
    repeat (3) @(negedge clk);

    // Receive 0x3C, then acknowledge
    send_rx(8'h3C, 1'b1);
    check("rx3c_irr_before_commit", 32'(sr_irr), 32'd0);
    @(negedge clk);
    check("rx3c_irr", 32'(sr_irr), 32'd1);
    check("rx3c_data", 32'(sr_r_data), 32'h3C);
    pulse_ack();
    check("rx3c_ack_irr", 32'(sr_irr), 32'd0);
    check("rx3c_ack_data", 32'(sr_r_data), 32'(cleared_data));

    // Framing error and a short glitch leave the pending state alone
    send_rx(8'hFF, 1'b0);
    repeat (6) @(negedge clk);
    check("ferr_irr", 32'(sr_irr), 32'd0);
    check("ferr_data", 32'(sr_r_data), 32'(cleared_data));
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_irr", 32'(sr_irr), 32'd0);
    check("glitch_data", 32'(sr_r_data), 32'(cleared_data));

    // Ack in the commit cycle: commit wins
    send_rx(8'h5A, 1'b1);
    pulse_ack();
    check("commit_ack_irr", 32'(sr_irr), 32'd1);
    check("commit_ack_data", 32'(sr_r_data), 32'h5A);
    pulse_ack();
    check("ack2_irr", 32'(sr_irr), 32'd0);
    pulse_ack();
    check("ack_idle_irr", 32'(sr_irr), 32'd0);
`ifdef CPU_IO_RX_FIFO_EN
    check("ack_idle_data", 32'(sr_r_data), 32'h00);
`else
    check("ack_idle_data", 32'(sr_r_data), 32'h5A);
`endif

    // Five bytes with no ack: overrun (register) or drop of the fifth (FIFO)
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i), 1'b1);
      @(negedge clk);
    end
`ifdef CPU_IO_RX_FIFO_EN
    for (int k = 1; k <= 4; k++) begin
      check("fifo_irr", 32'(sr_irr), 32'd1);
      check("fifo_head", 32'(sr_r_data), 32'(k));
      pulse_ack();
    end
    check("fifo_empty_irr", 32'(sr_irr), 32'd0);
    check("fifo_empty_data", 32'(sr_r_data), 32'h00);
`else
    check("overrun_irr", 32'(sr_irr), 32'd1);
    check("overrun_data", 32'(sr_r_data), 32'h05);
    pulse_ack();
    check("overrun_ack_irr", 32'(sr_irr), 32'd0);
    check("overrun_ack_data", 32'(sr_r_data), 32'h05);
`endif

    send_rx(8'h77, 1'b1);
    @(negedge clk);
    check("rx77_irr", 32'(sr_irr), 32'd1);
    check("rx77_data", 32'(sr_r_data), 32'h77);

    // Reset in the middle of a TX frame
    pulse_req(8'h96);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(uart_tx), 32'd1);
    check("midrst_busy", 32'(sr_w_busy), 32'd0);
    check("midrst_irr", 32'(sr_irr), 32'd0);
    check("midrst_data", 32'(sr_r_data), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    busys = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
      if (sr_w_busy !== 1'b0) busys++;
    end
    check("midrst_no_residual_tx", 32'(lows), 32'd0);
    check("midrst_no_residual_busy", 32'(busys), 32'd0);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
